// File: rtl/acc_pkg.sv
// Shared definitions for the accumulate datapath: scheduler state encoding,
// default run-count width and datapath status encodings.
package acc_pkg;

    localparam int ACC_CNT_BIT = 31;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LAUNCH = 2'b01,
        S_WAIT   = 2'b10,
        S_DRAIN  = 2'b11
    } state_e;

    // Datapath status as seen on {done, idle}.
    typedef enum logic [1:0] {
        DP_BUSY      = 2'b00,
        DP_IDLE      = 2'b01,
        DP_DONE      = 2'b10,
        DP_DONE_IDLE = 2'b11
    } dp_status_e;

    function automatic dp_status_e dp_status(input logic idle, input logic done);
        return dp_status_e'({done, idle});
    endfunction

endpackage

// File: rtl/acc_job_fifo.sv
// DEPTH x WIDTH synchronous FIFO with push/pop, flush, full/empty and level.
// DEPTH must be a power of two so the pointers wrap naturally.
module acc_job_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 31,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push_s, do_pop_s;

    // Next-state for storage, pointers and occupancy; flush overrides everything.
    always_comb begin
        do_push_s = push_i & ~full_o;
        do_pop_s  = pop_i & ~empty_o;
        mem_d     = mem_q;
        mem_d[wr_ptr_q] = do_push_s ? data_i : mem_q[wr_ptr_q];
        if (clr_i) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            level_d  = {LW{1'b0}};
        end else begin
            wr_ptr_d = do_push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
            rd_ptr_d = do_pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
            case ({do_push_s, do_pop_s})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (level_q == LVL_FULL);
    assign empty_o = (level_q == {LW{1'b0}});
    assign level_o = level_q;

endmodule

// File: rtl/acc_job_scheduler.sv
// Job scheduler for the 4-core accumulate datapath: queues row-count jobs,
// launches them one at a time, watches for completion and flags timeouts.
module acc_job_scheduler
    import acc_pkg::*;
#(
    parameter int                CNT_BIT  = ACC_CNT_BIT,
    parameter int                QDEPTH   = 2,
    parameter int                TO_BIT   = 16,
    parameter logic [TO_BIT-1:0] TIMEOUT  = 16'hFFFF,
    parameter int                JOBS_BIT = 8,
    localparam int               LW       = $clog2(QDEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                job_valid_i,
    input  logic [CNT_BIT-1:0]  job_count_i,
    output logic                job_ready_o,
    input  logic                abort_i,
    input  logic                err_clr_i,
    output logic                start_run_o,
    output logic [CNT_BIT-1:0]  run_count_o,
    input  logic                dp_idle_i,
    input  logic                dp_done_i,
    output logic                busy_o,
    output logic [JOBS_BIT-1:0] jobs_done_o,
    output logic                err_o,
    output logic [LW-1:0]       q_level_o
);

    state_e              state_q, state_d;
    logic [CNT_BIT-1:0]  run_cnt_q, run_cnt_d;
    logic [TO_BIT-1:0]   to_cnt_q, to_cnt_d;
    logic [JOBS_BIT-1:0] jobs_q, jobs_d;
    logic                err_q, err_d;
    logic                start_q, start_d;

    logic                fifo_push_s, fifo_pop_s;
    logic                fifo_full_s, fifo_empty_s;
    logic [CNT_BIT-1:0]  head_s;
    logic [LW-1:0]       fifo_level_s;
    logic [TO_BIT-1:0]   to_inc_s;

    // A push coinciding with abort is dropped along with the rest of the queue.
    assign fifo_push_s = job_valid_i & ~fifo_full_s & ~abort_i;
    assign to_inc_s    = to_cnt_q + TO_BIT'(1);

    acc_job_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (CNT_BIT)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .clr_i   (abort_i),
        .push_i  (fifo_push_s),
        .data_i  (job_count_i),
        .pop_i   (fifo_pop_s),
        .data_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (fifo_level_s)
    );

    // Next-state, counters and status; abort is applied last so it wins.
    always_comb begin
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        to_cnt_d   = to_cnt_q;
        jobs_d     = jobs_q;
        fifo_pop_s = 1'b0;
        err_d      = err_clr_i ? 1'b0 : err_q;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty_s && dp_idle_i) begin
                    fifo_pop_s = 1'b1;
                    if (head_s == {CNT_BIT{1'b0}}) begin
                        jobs_d = jobs_q + JOBS_BIT'(1);
                    end else begin
                        run_cnt_d = head_s;
                        state_d   = S_LAUNCH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                to_cnt_d = {TO_BIT{1'b0}};
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                to_cnt_d = to_inc_s;
                if (dp_done_i) begin
                    state_d = S_DRAIN;
                end else if (to_inc_s == TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (dp_idle_i) begin
                    jobs_d  = jobs_q + JOBS_BIT'(1);
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_i) begin
            state_d    = S_IDLE;
            fifo_pop_s = 1'b0;
            run_cnt_d  = run_cnt_q;
            to_cnt_d   = {TO_BIT{1'b0}};
            jobs_d     = jobs_q;
            err_d      = err_clr_i ? 1'b0 : err_q;
        end else begin
            fifo_pop_s = fifo_pop_s;
        end

        start_d = (state_d == S_LAUNCH);
    end

    // Scheduler state and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            run_cnt_q <= {CNT_BIT{1'b0}};
            to_cnt_q  <= {TO_BIT{1'b0}};
            jobs_q    <= {JOBS_BIT{1'b0}};
            err_q     <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            to_cnt_q  <= to_cnt_d;
            jobs_q    <= jobs_d;
            err_q     <= err_d;
            start_q   <= start_d;
        end
    end

    assign start_run_o = start_q;
    assign run_count_o = run_cnt_q;
    assign jobs_done_o = jobs_q;
    assign err_o       = err_q;
    assign busy_o      = (state_q != S_IDLE) | ~fifo_empty_s;
    assign job_ready_o = ~fifo_full_s;
    assign q_level_o   = fifo_level_s;

endmodule

// File: tb/tb_acc_job_scheduler.sv
// Directed bench for acc_job_scheduler: a cycle table for the single-job case
// followed by hand-written sequences for queueing, zero-count, timeout, abort and reset.
module tb_acc_job_scheduler;

    logic        clk;
    logic        reset_n;
    logic        job_valid_i;
    logic [30:0] job_count_i;
    logic        job_ready_o;
    logic        abort_i;
    logic        err_clr_i;
    logic        start_run_o;
    logic [30:0] run_count_o;
    logic        dp_idle_i;
    logic        dp_done_i;
    logic        busy_o;
    logic [7:0]  jobs_done_o;
    logic        err_o;
    logic [1:0]  q_level_o;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cyc = 0;

    acc_job_scheduler #(
        .CNT_BIT  (31),
        .QDEPTH   (2),
        .TO_BIT   (16),
        .TIMEOUT  (16'd8),
        .JOBS_BIT (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .job_valid_i (job_valid_i),
        .job_count_i (job_count_i),
        .job_ready_o (job_ready_o),
        .abort_i     (abort_i),
        .err_clr_i   (err_clr_i),
        .start_run_o (start_run_o),
        .run_count_o (run_count_o),
        .dp_idle_i   (dp_idle_i),
        .dp_done_i   (dp_done_i),
        .busy_o      (busy_o),
        .jobs_done_o (jobs_done_o),
        .err_o       (err_o),
        .q_level_o   (q_level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [30:0] cnt;
        logic        idle;
        logic        done;
        logic        e_start;
        logic [30:0] e_rc;
        logic        e_ready;
        logic        e_busy;
        logic [7:0]  e_jobs;
        logic        e_err;
        logic [1:0]  e_lvl;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic v, input logic [30:0] cnt, input logic idle,
                                input logic done, input logic e_start, input logic [30:0] e_rc,
                                input logic e_ready, input logic e_busy, input logic [7:0] e_jobs,
                                input logic [1:0] e_lvl);
        vec_t r;
        r.v = v; r.cnt = cnt; r.idle = idle; r.done = done;
        r.e_start = e_start; r.e_rc = e_rc; r.e_ready = e_ready; r.e_busy = e_busy;
        r.e_jobs = e_jobs; r.e_err = 1'b0; r.e_lvl = e_lvl;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start"}, 32'(start_run_o), 32'd0);
        chk({tag, "_rc"},    32'(run_count_o), 32'd0);
        chk({tag, "_ready"}, 32'(job_ready_o), 32'd1);
        chk({tag, "_busy"},  32'(busy_o),      32'd0);
        chk({tag, "_jobs"},  32'(jobs_done_o), 32'd0);
        chk({tag, "_err"},   32'(err_o),       32'd0);
        chk({tag, "_lvl"},   32'(q_level_o),   32'd0);
    endtask

    // Waits for a launch, checks its count, optional gap from the last done,
    // then marks the datapath busy and checks the pulse is a single cycle.
    task automatic wait_launch(input logic [30:0] exp_cnt, input bit gap_chk);
        int k = 0;
        while (start_run_o !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk("launch_seen", 32'(k < 20), 32'd1);
        chk("launch_count", 32'(run_count_o), 32'(exp_cnt));
        if (gap_chk) begin
            chk("done_to_start_gap", 32'(cyc - done_cyc >= 3), 32'd1);
        end
        dp_idle_i = 1'b0;
        step();
        chk("start_one_cycle", 32'(start_run_o), 32'd0);
    endtask

    task automatic finish_job(input int lat);
        repeat (lat) step();
        dp_done_i = 1'b1;
        done_cyc  = cyc;
        step();
        dp_done_i = 1'b0;
        dp_idle_i = 1'b1;
        step();
    endtask

    task automatic push(input logic [30:0] cnt);
        job_valid_i = 1'b1;
        job_count_i = cnt;
        step();
        job_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_start;
        // Single job: push on row 2, launch on row 4, done on row 12, retire visible on row 14.
        tbl[0]  = mk(1'b0, 31'd0, 1'b1, 1'b0,  1'b0, 31'd0, 1'b1, 1'b0, 8'd0, 2'd0);
        tbl[1]  = mk(1'b0, 31'd0, 1'b1, 1'b0,  1'b0, 31'd0, 1'b1, 1'b0, 8'd0, 2'd0);
        tbl[2]  = mk(1'b1, 31'd4, 1'b1, 1'b0,  1'b0, 31'd0, 1'b1, 1'b0, 8'd0, 2'd0);
        tbl[3]  = mk(1'b0, 31'd0, 1'b1, 1'b0,  1'b0, 31'd0, 1'b1, 1'b1, 8'd0, 2'd1);
        tbl[4]  = mk(1'b0, 31'd0, 1'b1, 1'b0,  1'b1, 31'd4, 1'b1, 1'b1, 8'd0, 2'd0);
        for (int i = 5; i < 12; i++) begin
            tbl[i] = mk(1'b0, 31'd0, 1'b0, 1'b0, 1'b0, 31'd4, 1'b1, 1'b1, 8'd0, 2'd0);
        end
        tbl[12] = mk(1'b0, 31'd0, 1'b0, 1'b1,  1'b0, 31'd4, 1'b1, 1'b1, 8'd0, 2'd0);
        tbl[13] = mk(1'b0, 31'd0, 1'b1, 1'b0,  1'b0, 31'd4, 1'b1, 1'b1, 8'd0, 2'd0);
        tbl[14] = mk(1'b0, 31'd0, 1'b1, 1'b0,  1'b0, 31'd4, 1'b1, 1'b0, 8'd1, 2'd0);

        reset_n = 1'b0; job_valid_i = 1'b0; job_count_i = 31'd0; abort_i = 1'b0;
        err_clr_i = 1'b0; dp_idle_i = 1'b1; dp_done_i = 1'b0;
        step(); step();
        chk_reset_vals("rst");
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            job_valid_i = tbl[i].v;
            job_count_i = tbl[i].cnt;
            dp_idle_i   = tbl[i].idle;
            dp_done_i   = tbl[i].done;
            chk($sformatf("t%0d_start", i), 32'(start_run_o), 32'(tbl[i].e_start));
            chk($sformatf("t%0d_rc", i),    32'(run_count_o), 32'(tbl[i].e_rc));
            chk($sformatf("t%0d_ready", i), 32'(job_ready_o), 32'(tbl[i].e_ready));
            chk($sformatf("t%0d_busy", i),  32'(busy_o),      32'(tbl[i].e_busy));
            chk($sformatf("t%0d_jobs", i),  32'(jobs_done_o), 32'(tbl[i].e_jobs));
            chk($sformatf("t%0d_err", i),   32'(err_o),       32'(tbl[i].e_err));
            chk($sformatf("t%0d_lvl", i),   32'(q_level_o),   32'(tbl[i].e_lvl));
            step();
        end
        job_valid_i = 1'b0; dp_idle_i = 1'b1; dp_done_i = 1'b0;

        // Back-to-back: 5 launches while 7 and 9 fill the queue; a push while full is ignored.
        job_valid_i = 1'b1; job_count_i = 31'd5;
        step();
        chk("b2b_lvl_a", 32'(q_level_o), 32'd1);
        job_count_i = 31'd7;
        step();
        chk("b2b_start5", 32'(start_run_o), 32'd1);
        chk("b2b_rc5", 32'(run_count_o), 32'd5);
        chk("b2b_lvl_b", 32'(q_level_o), 32'd1);
        job_count_i = 31'd9; dp_idle_i = 1'b0;
        step();
        chk("b2b_lvl_full", 32'(q_level_o), 32'd2);
        chk("b2b_ready_full", 32'(job_ready_o), 32'd0);
        job_count_i = 31'd99;
        step();
        job_valid_i = 1'b0;
        chk("b2b_push_when_full", 32'(q_level_o), 32'd2);
        finish_job(0);
        wait_launch(31'd7, 1'b1);
        finish_job(2);
        wait_launch(31'd9, 1'b1);
        finish_job(2);
        chk("b2b_jobs", 32'(jobs_done_o), 32'd4);
        chk("b2b_idle", 32'(busy_o), 32'd0);

        // Zero-count job retires without a pulse; a following job launches normally.
        job_valid_i = 1'b1; job_count_i = 31'd0;
        step();
        job_valid_i = 1'b0;
        chk("zero_start_a", 32'(start_run_o), 32'd0);
        chk("zero_lvl", 32'(q_level_o), 32'd1);
        step();
        chk("zero_start_b", 32'(start_run_o), 32'd0);
        chk("zero_jobs", 32'(jobs_done_o), 32'd5);
        chk("zero_busy", 32'(busy_o), 32'd0);
        push(31'd2);
        wait_launch(31'd2, 1'b0);
        finish_job(1);
        chk("zero_next_jobs", 32'(jobs_done_o), 32'd6);

        // Timeout after TIMEOUT wait cycles; the job is not retired.
        push(31'd3);
        wait_launch(31'd3, 1'b0);
        repeat (6) step();
        chk("to_err_early", 32'(err_o), 32'd0);
        chk("to_busy_early", 32'(busy_o), 32'd1);
        step(); step();
        chk("to_err_set", 32'(err_o), 32'd1);
        chk("to_back_idle", 32'(busy_o), 32'd0);
        chk("to_jobs_kept", 32'(jobs_done_o), 32'd6);

        // Second timeout with a simultaneous clear: set wins; err does not block the launch.
        dp_idle_i = 1'b1;
        push(31'd8);
        wait_launch(31'd8, 1'b0);
        repeat (7) step();
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        chk("to_set_beats_clr", 32'(err_o), 32'd1);
        chk("to2_idle", 32'(busy_o), 32'd0);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        chk("err_clr", 32'(err_o), 32'd0);
        chk("to2_jobs_kept", 32'(jobs_done_o), 32'd6);

        // Abort with one job in WAIT and two queued; a later done is ignored.
        dp_idle_i = 1'b1;
        push(31'd6);
        wait_launch(31'd6, 1'b0);
        push(31'd12);
        push(31'd13);
        chk("ab_lvl_full", 32'(q_level_o), 32'd2);
        abort_i = 1'b1; job_valid_i = 1'b1; job_count_i = 31'd14;
        step();
        abort_i = 1'b0; job_valid_i = 1'b0;
        chk("ab_lvl", 32'(q_level_o), 32'd0);
        chk("ab_busy", 32'(busy_o), 32'd0);
        chk("ab_start", 32'(start_run_o), 32'd0);
        chk("ab_ready", 32'(job_ready_o), 32'd1);
        chk("ab_jobs", 32'(jobs_done_o), 32'd6);
        chk("ab_err", 32'(err_o), 32'd0);
        dp_done_i = 1'b1;
        step();
        dp_done_i = 1'b0; dp_idle_i = 1'b1;
        n_start = 0;
        for (int i = 0; i < 6; i++) begin
            n_start += int'(start_run_o) + int'(busy_o);
            step();
        end
        chk("ab_no_activity", 32'(n_start), 32'd0);
        chk("ab_done_ignored", 32'(jobs_done_o), 32'd6);

        // Abort with a push into an empty, idle queue: the push is discarded.
        abort_i = 1'b1; job_valid_i = 1'b1; job_count_i = 31'd15;
        step();
        abort_i = 1'b0; job_valid_i = 1'b0;
        chk("ab2_lvl", 32'(q_level_o), 32'd0);
        step();
        chk("ab2_start", 32'(start_run_o), 32'd0);
        chk("ab2_busy", 32'(busy_o), 32'd0);

        // Asynchronous reset during the launch cycle.
        push(31'd3);
        n_start = 0;
        while (start_run_o !== 1'b1 && n_start < 20) begin
            step();
            n_start++;
        end
        chk("rst_launch_seen", 32'(start_run_o), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_start", 32'(start_run_o), 32'd0);
        chk("rst_async_jobs", 32'(jobs_done_o), 32'd0);
        step(); step();
        reset_n = 1'b1;
        step();
        chk_reset_vals("rst_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
